// File: rtl/instr_loader.sv
// Button-driven instruction loader: two debounced presses assemble a 32-bit word
// from 16 slide switches, then write it to instruction memory with a valid/ready
// handshake at sequential addresses. Define INSTR_LOADER_ECHO_EN to add the echo
// output that feeds the seven-segment display.
module instr_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned MAX_WORDS       = 64,
  localparam int unsigned CNT_W          = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [15:0]      sw,
  input  logic             enter,
  output logic             wr_valid,
  input  logic             wr_ready,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             expect_hi,
  output logic [CNT_W-1:0] word_count,
  output logic             full
`ifdef INSTR_LOADER_ECHO_EN
  ,
  output logic [31:0]      echo
`endif
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_LO,
    ST_HI,
    ST_WRITE,
    ST_FULL
  } state_e;

  // Reset asserts asynchronously but releases two edges after reset_n rises,
  // so no flop leaves reset on an edge that races the deassertion.
  logic rst_meta_q, rst_sync_q;
  logic rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  assign rst_n = rst_sync_q;

  // Button synchronizer and debouncer.
  logic            enter_meta_q, enter_sync_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            db_level_q, db_level_d;
  logic            press_q, press_d;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first; a path that leaves a variable unassigned infers a latch.
  always_comb begin
    db_cnt_d   = '0;
    db_level_d = db_level_q;
    if (enter_sync_q != db_level_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_level_d = enter_sync_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
    press_d = db_level_d & ~db_level_q;
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enter_meta_q <= 1'b0;
      enter_sync_q <= 1'b0;
      db_cnt_q     <= '0;
      db_level_q   <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      enter_meta_q <= enter;
      enter_sync_q <= enter_meta_q;
      db_cnt_q     <= db_cnt_d;
      db_level_q   <= db_level_d;
      press_q      <= press_d;
    end
  end

  // Loader FSM with registered outputs.
  state_e           state_q, state_d;
  logic             wr_valid_q, wr_valid_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic             full_q, full_d;
  logic             expect_hi_q, expect_hi_d;
  logic [CNT_W-1:0] count_inc;

  assign count_inc = word_count_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    wr_valid_d   = wr_valid_q;
    wr_data_d    = wr_data_q;
    wr_addr_d    = wr_addr_q;
    word_count_d = word_count_q;
    full_d       = full_q;
    expect_hi_d  = expect_hi_q;

    unique case (state_q)
      ST_LO: begin
        if (press_q) begin
          wr_data_d[15:0] = sw;
          state_d         = ST_HI;
          expect_hi_d     = 1'b1;
        end
      end
      ST_HI: begin
        if (press_q) begin
          wr_data_d[31:16] = sw;
          state_d          = ST_WRITE;
          expect_hi_d      = 1'b0;
          wr_valid_d       = 1'b1;
        end
      end
      ST_WRITE: begin
        // Presses are dropped here; only the handshake advances the FSM.
        if (wr_ready) begin
          word_count_d = count_inc;
          wr_addr_d    = wr_addr_q + 32'd4;
          wr_valid_d   = 1'b0;
          if (count_inc == CNT_W'(MAX_WORDS)) begin
            state_d = ST_FULL;
            full_d  = 1'b1;
          end else begin
            state_d = ST_LO;
          end
        end
      end
      ST_FULL: begin
        full_d     = 1'b1;
        wr_valid_d = 1'b0;
      end
      default: state_d = ST_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LO;
      wr_valid_q   <= 1'b0;
      wr_data_q    <= '0;
      wr_addr_q    <= BASE_ADDR;
      word_count_q <= '0;
      full_q       <= 1'b0;
      expect_hi_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_valid_q   <= wr_valid_d;
      wr_data_q    <= wr_data_d;
      wr_addr_q    <= wr_addr_d;
      word_count_q <= word_count_d;
      full_q       <= full_d;
      expect_hi_q  <= expect_hi_d;
    end
  end

  assign wr_valid   = wr_valid_q;
  assign wr_data    = wr_data_q;
  assign wr_addr    = wr_addr_q;
  assign word_count = word_count_q;
  assign full       = full_q;
  assign expect_hi  = expect_hi_q;

`ifdef INSTR_LOADER_ECHO_EN
  // While waiting for the upper half, show only what has been entered so far.
  assign echo = {(state_q == ST_HI) ? 16'h0000 : wr_data_q[31:16], wr_data_q[15:0]};
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: a directed vector table, hand-written
// corner sequences and a randomized run against an address/data model.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] sw = '0;
  logic        enter = 1'b0;
  logic        wr_ready = 1'b0;

  logic        wr_valid1, wr_valid2;
  logic [31:0] wr_addr1, wr_addr2, wr_data1, wr_data2;
  logic        expect_hi1, expect_hi2, full1, full2;
  logic [6:0]  word_count1;
  logic [1:0]  word_count2;
`ifdef INSTR_LOADER_ECHO_EN
  logic [31:0] echo1, echo2;
`endif

  always #5 clk = ~clk;

  instr_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .sw(sw), .enter(enter),
    .wr_valid(wr_valid1), .wr_ready(wr_ready), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .expect_hi(expect_hi1), .word_count(word_count1), .full(full1)
`ifdef INSTR_LOADER_ECHO_EN
    , .echo(echo1)
`endif
  );

  instr_loader #(.DEBOUNCE_CYCLES(4), .BASE_ADDR(32'h100), .MAX_WORDS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .sw(sw), .enter(enter),
    .wr_valid(wr_valid2), .wr_ready(wr_ready), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .expect_hi(expect_hi2), .word_count(word_count2), .full(full2)
`ifdef INSTR_LOADER_ECHO_EN
    , .echo(echo2)
`endif
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    int          stall;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    int          exp_count;
  } vec_t;

  wr_t log1[$];
  wr_t log2[$];
  int  valid2_cycles = 0;
  int  checks = 0;
  int  errors = 0;
  bit  rnd_ready = 1'b0;

  // Handshake monitor: a write is committed on the edge following a negedge
  // where both valid and ready are high.
  always @(negedge clk) begin
    if (wr_valid1 && wr_ready) log1.push_back({wr_addr1, wr_data1});
    if (wr_valid2 && wr_ready) log2.push_back({wr_addr2, wr_data2});
    if (wr_valid2) valid2_cycles++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) wr_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic press(input logic [15:0] v);
    sw    = v;
    enter = 1'b1;
    repeat (8) tick();
    enter = 1'b0;
    repeat (8) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    log1.delete();
    log2.delete();
    valid2_cycles = 0;
  endtask

  task automatic wait_valid(input logic want, input int budget, input string name);
    int n = 0;
    while (wr_valid1 !== want && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(wr_valid1), 64'(want));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[4];
    wr_t         exp_q[$];
    logic [31:0] a0, d0;
    int          n_high, guard;
    bit          stable;

    vecs[0] = '{16'h0013, 16'h0000, 0, 32'h0000_0000, 32'h0000_0013, 1};
    vecs[1] = '{16'h5A5A, 16'hA5A5, 3, 32'h0000_0004, 32'hA5A5_5A5A, 2};
    vecs[2] = '{16'hFFFF, 16'h0001, 1, 32'h0000_0008, 32'h0001_FFFF, 3};
    vecs[3] = '{16'h0000, 16'hFFFF, 5, 32'h0000_000C, 32'hFFFF_0000, 4};

    // Reset values while reset_n is held low.
    repeat (2) tick();
    check("rst_valid", 64'(wr_valid1), 64'(1'b0));
    check("rst_addr", 64'(wr_addr1), 64'(32'h0));
    check("rst_addr2", 64'(wr_addr2), 64'(32'h100));
    check("rst_data", 64'(wr_data1), 64'(32'h0));
    check("rst_count", 64'(word_count1), 64'(0));
    check("rst_full", 64'(full1), 64'(1'b0));
    check("rst_expect_hi", 64'(expect_hi1), 64'(1'b0));
    do_reset();

    // Directed vector table.
    for (int i = 0; i < 4; i++) begin
      press(vecs[i].lo);
      check("vec_expect_hi_after_lo", 64'(expect_hi1), 64'(1'b1));
      wr_ready = 1'b0;
      press(vecs[i].hi);
      check("vec_valid", 64'(wr_valid1), 64'(1'b1));
      check("vec_addr", 64'(wr_addr1), 64'(vecs[i].exp_addr));
      check("vec_data", 64'(wr_data1), 64'(vecs[i].exp_data));
      check("vec_expect_hi_in_write", 64'(expect_hi1), 64'(1'b0));
      repeat (vecs[i].stall) tick();
      wr_ready = 1'b1;
      wait_valid(1'b0, 10, "vec_valid_drop");
      wr_ready = 1'b0;
      check("vec_count", 64'(word_count1), 64'(vecs[i].exp_count));
      check("vec_next_addr", 64'(wr_addr1), 64'(vecs[i].exp_addr + 32'd4));
      check("vec_log_size", 64'(log1.size()), 64'(i + 1));
      if (log1.size() > i) check("vec_log_entry", 64'(log1[i]), {vecs[i].exp_addr, vecs[i].exp_data});
    end

    // Bouncing input: short pulses give no event, a steady level gives one.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      enter = ~enter;
      repeat (2) tick();
    end
    check("bounce_no_event", 64'(expect_hi1), 64'(1'b0));
    enter = 1'b1;
    repeat (10) tick();
    check("bounce_one_event", 64'(expect_hi1), 64'(1'b1));
    enter = 1'b0;
    repeat (10) tick();
    check("bounce_release_no_event", 64'(expect_hi1), 64'(1'b1));
    check("bounce_no_write", 64'(wr_valid1), 64'(1'b0));

    // Stall: ready low for 7 cycles gives 8 valid cycles with stable outputs.
    do_reset();
    press(16'hBEEF);
    wr_ready = 1'b0;
    sw = 16'hDEAD;
    enter = 1'b1;
    wait_valid(1'b1, 20, "stall_valid_rise");
    enter = 1'b0;
    a0 = wr_addr1;
    d0 = wr_data1;
    n_high = 0;
    guard = 0;
    stable = 1'b1;
    while (wr_valid1 && guard < 40) begin
      n_high++;
      if (wr_addr1 !== a0 || wr_data1 !== d0) stable = 1'b0;
      if (n_high == 8) wr_ready = 1'b1;
      tick();
      guard++;
    end
    wr_ready = 1'b0;
    check("stall_valid_cycles", 64'(n_high), 64'(8));
    check("stall_stable", 64'(stable), 64'(1'b1));
    check("stall_data", 64'(d0), 64'(32'hDEAD_BEEF));
    check("stall_addr", 64'(a0), 64'(32'h0));
    check("stall_count", 64'(word_count1), 64'(1));
    repeat (10) tick();

    // Presses during a long stall are dropped, not queued.
    press(16'h1111);
    press(16'h2222);
    check("drop_valid", 64'(wr_valid1), 64'(1'b1));
    press(16'h3333);
    press(16'h4444);
    check("drop_still_valid", 64'(wr_valid1), 64'(1'b1));
    check("drop_data_held", 64'(wr_data1), 64'(32'h2222_1111));
    check("drop_addr_held", 64'(wr_addr1), 64'(32'h4));
    wr_ready = 1'b1;
    wait_valid(1'b0, 10, "drop_accept");
    wr_ready = 1'b0;
    check("drop_count", 64'(word_count1), 64'(2));
    repeat (20) tick();
    check("drop_not_queued", 64'(expect_hi1), 64'(1'b0));
    press(16'h5555);
    check("drop_resume", 64'(expect_hi1), 64'(1'b1));

    // Full at MAX_WORDS=2 on the second instance.
    do_reset();
    wr_ready = 1'b1;
    press(16'h0001);
    press(16'h0002);
    press(16'h0003);
    press(16'h0004);
    check("full_log_size", 64'(log2.size()), 64'(2));
    if (log2.size() >= 2) begin
      check("full_addr0", 64'(log2[0].addr), 64'(32'h100));
      check("full_data0", 64'(log2[0].data), 64'(32'h0002_0001));
      check("full_addr1", 64'(log2[1].addr), 64'(32'h104));
      check("full_data1", 64'(log2[1].data), 64'(32'h0004_0003));
    end
    check("full_flag", 64'(full2), 64'(1'b1));
    check("full_count", 64'(word_count2), 64'(2));
    check("full_addr_after", 64'(wr_addr2), 64'(32'h108));
    valid2_cycles = 0;
    press(16'h0005);
    press(16'h0006);
    check("full_ignore_valid", 64'(valid2_cycles), 64'(0));
    check("full_ignore_log", 64'(log2.size()), 64'(2));
    check("full_held", 64'(full2), 64'(1'b1));
    check("full_main_not_full", 64'(full1), 64'(1'b0));
    wr_ready = 1'b0;

    // Reset in the middle of a write.
    do_reset();
    press(16'hAAAA);
    press(16'hBBBB);
    check("midrst_valid_before", 64'(wr_valid1), 64'(1'b1));
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    wr_ready = 1'b1;
    #1;
    check("midrst_valid_drop", 64'(wr_valid1), 64'(1'b0));
    check("midrst_count", 64'(word_count1), 64'(0));
    check("midrst_addr", 64'(wr_addr1), 64'(32'h0));
    check("midrst_addr2", 64'(wr_addr2), 64'(32'h100));
    check("midrst_expect_hi", 64'(expect_hi1), 64'(1'b0));
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    check("midrst_no_write", 64'(log1.size()), 64'(0));
    check("midrst_idle", 64'(wr_valid1), 64'(1'b0));
    wr_ready = 1'b0;

`ifdef INSTR_LOADER_ECHO_EN
    do_reset();
    press(16'hBEEF);
    check("echo_lo", 64'(echo1), 64'(32'h0000_BEEF));
    press(16'hDEAD);
    check("echo_full", 64'(echo1), 64'(32'hDEAD_BEEF));
    wr_ready = 1'b1;
    wait_valid(1'b0, 10, "echo_accept");
    wr_ready = 1'b0;
    press(16'h1234);
    check("echo_hi_masks_upper", 64'(echo1), 64'(32'h0000_1234));
`endif

    // Randomized run: glitches, random data and random ready against the model.
    do_reset();
    exp_q.delete();
    rnd_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      logic [15:0] lo, hi;
      int          n;
      if ($urandom_range(0, 1) == 1) begin
        enter = 1'b1;
        repeat ($urandom_range(1, 3)) tick();
        enter = 1'b0;
        repeat (8) tick();
      end
      lo = 16'($urandom);
      hi = 16'($urandom);
      press(lo);
      press(hi);
      exp_q.push_back({32'h0 + 32'(4 * k), hi, lo});
      n = 0;
      while (int'(word_count1) != k + 1 && n < 300) begin
        tick();
        n++;
      end
      check("rnd_count", 64'(word_count1), 64'(k + 1));
    end
    rnd_ready = 1'b0;
    wr_ready = 1'b0;
    check("rnd_log_size", 64'(log1.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log1.size(); i++) begin
      check("rnd_write", 64'(log1[i]), 64'(exp_q[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, stable-input cycles required before a button level is accepted (10 ms at 100 MHz).
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first word written.
REQ-003 Parameter MAX_WORDS, default 64, number of words accepted before the loader reports full.
REQ-004 clk  input  1  single system clock, all state on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous, active-low.
REQ-006 sw  input  16  raw slide switches, one half-word.
REQ-007 enter  input  1  raw pushbutton, asynchronous to clk, bouncing.
REQ-008 wr_valid  output  1  write request to instruction memory.
REQ-009 wr_ready  input  1  memory accepts the write when high with wr_valid.
REQ-010 wr_addr  output  32  byte address of the current write.
REQ-011 wr_data  output  32  assembled word.
REQ-012 expect_hi  output  1  high when the next press captures the upper half-word.
REQ-013 word_count  output  ceil(log2(MAX_WORDS+1))  words committed so far.
REQ-014 full  output  1  MAX_WORDS words committed.

Function
REQ-015 enter SHALL pass a 2-flop synchronizer, then a debounce counter that resets on any change and updates the debounced level after DEBOUNCE_CYCLES consecutive equal samples.
REQ-016 A press event SHALL be a single-cycle pulse on the debounced 0->1 transition; release produces no event.
REQ-017 FSM states: LO, HI, WRITE, FULL; reset state LO.
REQ-018 LO: press -> wr_data[15:0] <= sw, go HI.
REQ-019 HI: press -> wr_data[31:16] <= sw, go WRITE, wr_valid rises the next cycle after the press pulse.
REQ-020 WRITE: wr_valid high, wr_addr and wr_data held stable until wr_valid && wr_ready on a rising edge.
REQ-021 On acceptance: word_count +1, wr_addr +4, wr_valid low the following cycle; next state FULL if the new count equals MAX_WORDS, else LO.
REQ-022 Press events in WRITE or FULL SHALL be ignored and not queued.
REQ-023 wr_ready while not in WRITE SHALL have no effect.
REQ-024 FULL: full = 1, wr_valid = 0, state held until reset.
REQ-025 expect_hi = 1 only in HI.
REQ-026 wr_addr = BASE_ADDR + 4*word_count always; 32-bit arithmetic, wraps modulo 2^32.
REQ-027 A press shorter than DEBOUNCE_CYCLES SHALL produce no event.

Reset
REQ-028 reset_n low SHALL immediately force: state LO, wr_valid 0, wr_data 0, wr_addr BASE_ADDR, word_count 0, full 0, expect_hi 0, debounce counter 0, debounced level 0, synchronizer flops 0.
REQ-029 Reset asserted during WRITE SHALL drop wr_valid without completing the transfer; that word is not counted.
REQ-030 Deassertion SHALL be synchronized so the first state change occurs no earlier than the second rising edge after reset_n rises.

Configuration
REQ-031 Macro INSTR_LOADER_ECHO_EN defined: add output echo[31:0], equal to {wr_data[31:16], wr_data[15:0]} as currently assembled, upper half reading 0 while in HI, reset value 0; drives the seven-segment display mux for entry feedback.
REQ-032 Macro undefined: echo port absent, all other behaviour identical.

Verification (DEBOUNCE_CYCLES=4 in bench)
REQ-033 Reset, sw=16'h0013 press, sw=16'h0000 press, wr_ready=1 -> one write, wr_addr=0, wr_data=32'h0000_0013, word_count=1, expect_hi=0.
REQ-034 enter toggled every 2 cycles for 20 cycles, then held high 10 cycles -> exactly one press event, expect_hi=1.
REQ-035 Word 32'hDEAD_BEEF entered, wr_ready low 7 cycles -> wr_valid high 8 cycles, data/addr stable, extra presses during the stall ignored, count 1 after acceptance.
REQ-036 MAX_WORDS=2, BASE_ADDR=32'h100, two words written -> addrs 32'h100, 32'h104; full=1; third press ignored, wr_valid stays 0.
REQ-037 reset_n pulsed low mid-WRITE -> wr_valid 0 in the same cycle, word_count 0, wr_addr=BASE_ADDR, state LO.
REQ-038 With INSTR_LOADER_ECHO_EN, sw=16'hBEEF press -> echo=32'h0000_BEEF; sw=16'hDEAD press -> echo=32'hDEAD_BEEF.
